mmio_uart_tx: RTL
=================

# mmio_uart_tx

Memory-mapped serial transmit peripheral that sits on the CPU memory bus as a responder. It decodes CPU read and write strobes within a small address window and buffers written bytes in a FIFO. It serializes those bytes onto a single 8-N-1 UART line, and reports status back to the CPU through a readable register. Read data is returned combinationally in the same cycle as the CPU read strobe, so no wait states are needed.

## Interface
Parameters:
- ADDR_WIDTH, 16, bus address width
- DATA_WIDTH, 8, bus data width (fixed at 8)
- BASE_ADDR, 16'hE000, base of the 4-byte register window
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥ 2)
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, ≥ 2)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- mem_address  input  ADDR_WIDTH  address driven by CPU
- mem_read  input  1  CPU read strobe
- mem_write  input  1  CPU write strobe
- mem_wdata  input  DATA_WIDTH  data driven from CPU
- mem_rdata  output  DATA_WIDTH  data driven to CPU (combinational)
- sel  output  1  high when mem_address lies in [BASE_ADDR, BASE_ADDR+3]
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress or FIFO non-empty

## Operation
Register map (offset from BASE_ADDR):
- 0 DATA
  - Write: push mem_wdata into the FIFO.
  - Read: returns 0x00, no side effect.
- 1 STATUS, read-only bits except bit3:
  - bit0: shifter active
  - bit1: FIFO full
  - bit2: FIFO empty
  - bit3: sticky overflow
  - bits7:4 = 0
  - Writing with bit3 = 1 clears overflow; other bits are ignored.
- 2, 3: reserved. Read 0x00; writes are ignored.

Bus decode:
- mem_rdata = 0x00 whenever sel = 0 or mem_read = 0.
- Reads have no side effects.

FIFO:
- Push is accepted when FIFO count < FIFO_DEPTH, evaluated before the edge.
- A push while full is dropped and sets overflow, even if a pop occurs on the same edge.
- Simultaneous push (not full) and pop: count is unchanged, and both happen.

Transmitter FSM states: IDLE → START → DATA → STOP → (IDLE or START).
- IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register, go to START, and clear the bit counter.
- START: tx = 0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles.
- STOP: tx = 1 for CLKS_PER_BIT cycles. At the end:
  - FIFO non-empty: pop and go straight to START (back-to-back frames, no idle gap).
  - FIFO empty: go to IDLE.
- busy = (state ≠ IDLE) | ~fifo_empty.

Reset values: tx = 1, busy = 0, sel/mem_rdata per decode (mem_rdata = 0x00 unless read), FIFO empty, overflow = 0, state IDLE, all counters 0.

## Timing
- Write latency: DATA write sampled at edge N with an empty FIFO and FSM in IDLE:
  - The FIFO is non-empty after edge N.
  - The FSM pops at edge N+1, so tx falls after edge N+1.
- Frame length: 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity).
- Bit counter wrap: the baud counter runs 0..CLKS_PER_BIT-1 and advances the bit/state on terminal count.
- STATUS read reflects state registered before the current edge. A read in the same cycle as a write does not see that write.
- Reset mid-frame: reset_n low forces tx = 1 and clears all state immediately, without waiting for a clock. After release, the next frame starts cleanly from IDLE.
- Overflow clear and overflowing push on the same edge: set wins.

## Configuration
- UART_TX_PARITY_EN
  - Defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP. The FSM gains a PARITY state, and the frame is 11 bits.
  - Undefined: no PARITY state, 8-N-1 framing.
- Register map and STATUS are identical in both builds.

## Test plan
- Reset: assert reset_n = 0 mid-cycle → tx = 1 and busy = 0 immediately. A STATUS read (BASE+1) returns 0x04.
- CLKS_PER_BIT = 4, write 0xA5 to BASE:
  - tx low from edge N+1 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then high for 4 cycles.
  - busy drops after 40 cycles.
- Six back-to-back DATA writes 0x01–0x06: 0x01 is popped at edge 1, 0x02–0x05 fill the FIFO, and 0x06 is dropped.
  - STATUS = 0x0B (active, full, overflow).
  - Writing 0x08 to BASE+1 gives STATUS bit3 = 0.
  - Exactly five frames appear on tx, with no gap between them.
- Address BASE-1 and BASE+4 with read/write → sel = 0, mem_rdata = 0x00, no push, tx stays high.
- Reset mid-frame (during bit 3 of 0xFF) → tx = 1 immediately. After release, writing 0x00 produces a clean frame.
- Build with UART_TX_PARITY_EN, write 0x07 → parity bit = 1, frame is 44 cycles at CLKS_PER_BIT = 4.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: CPU-bus responder with a small TX FIFO feeding an 8-N-1 UART line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 16'hE000,
  parameter int unsigned           CLKS_PER_BIT = 16,
  parameter int unsigned           FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  sel,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Address decode: an extra MSB keeps addresses below the base from aliasing into the window
  logic [ADDR_WIDTH:0] addr_diff;
  logic [1:0]          reg_offset;
  logic                data_wr;
  logic                status_wr;

  assign addr_diff  = {1'b0, mem_address} - {1'b0, BASE_ADDR};
  assign sel        = (addr_diff[ADDR_WIDTH:2] == '0);
  assign reg_offset = addr_diff[1:0];
  assign data_wr    = mem_write & sel & (reg_offset == 2'd0);
  assign status_wr  = mem_write & sel & (reg_offset == 2'd1) & mem_wdata[3];

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [7:0]       fifo_head;
  logic             overflow;

  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = data_wr & ~fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // An overflowing push outranks a clear on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (data_wr && fifo_full) begin
      overflow <= 1'b1;
    end else if (status_wr) begin
      overflow <= 1'b0;
    end
  end

  state_t            state;
  state_t            state_n;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_n;
  logic [2:0]        bit_cnt;
  logic [2:0]        bit_n;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_n;
  logic              baud_done;
  logic              tx_c;

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_bit <= 1'b0;
    end else if (pop) begin
      parity_bit <= ^fifo_head;
    end
  end
`endif

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    pop     = 1'b0;
    tx_c    = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_head;
          bit_n   = '0;
          baud_n  = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        tx_c = 1'b0;
        if (baud_done) begin
          baud_n  = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        tx_c = shift_reg[0];
        if (baud_done) begin
          baud_n  = '0;
          shift_n = shift_reg >> 1;
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_c = parity_bit;
        if (baud_done) begin
          baud_n  = '0;
          state_n = S_STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_c = 1'b1;
        if (baud_done) begin
          baud_n = '0;
          // Chain straight into the next start bit when more data is queued
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_head;
            bit_n   = '0;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  logic [7:0] status;

  assign tx     = tx_c;
  assign busy   = (state != S_IDLE) | ~fifo_empty;
  assign status = {4'b0000, overflow, fifo_empty, fifo_full, state != S_IDLE};

  always_comb begin
    mem_rdata = '0;
    if (sel && mem_read && (reg_offset == 2'd1)) mem_rdata = DATA_WIDTH'(status);
  end

endmodule
